mesi_cpu_agent: RTL and testbench
=================================

Name: mesi_cpu_agent

Overview:
- Per-CPU coherence agent: the cache-side end of the mesi_isc protocol. One instance per CPU port (0..3).
- Issues main-bus requests (RD_BROAD / WR_BROAD / WR writeback) toward mesi_isc.
- Answers coherence-bus commands (WR_SNOOP / RD_SNOOP / EN_WR / EN_RD) with cbus_ack.
- Keeps a small direct-mapped MESI tag/state table. No data storage; data movement is outside this block.

Parameters:
- ADDR_WIDTH, 32, address width of mbus/cbus/cpu addresses.
- MBUS_CMD_WIDTH, 3, main-bus command width.
- CBUS_CMD_WIDTH, 3, coherence-bus command width.
- LINES_LOG2, 2, log2 of table entries (4 lines).
- OFFSET_WIDTH, 2, line-offset bits. Ignored for all compares; zero on all mbus_addr_o.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  CPU request valid.
- cpu_wr_i  in  1  1 = write, 0 = read; qualified by cpu_req_i.
- cpu_addr_i  in  ADDR_WIDTH  CPU request address.
- cpu_ready_o  out  1  agent can accept a request this cycle.
- cpu_done_o  out  1  one-cycle pulse: accepted request complete.
- mbus_cmd_o  out  MBUS_CMD_WIDTH  main-bus command to mesi_isc.
- mbus_addr_o  out  ADDR_WIDTH  line-aligned main-bus address.
- mbus_ack_i  in  1  main-bus acknowledge from mesi_isc.
- cbus_cmd_i  in  CBUS_CMD_WIDTH  coherence command from mesi_isc.
- cbus_addr_i  in  ADDR_WIDTH  coherence address.
- cbus_ack_o  out  1  coherence acknowledge, one-cycle pulse.

Behaviour:
- Encodings:
  - mbus: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4.
  - cbus: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
  - Line state: I=0, S=1, E=2, M=3.
- Address fields:
  - index = addr[OFFSET_WIDTH+LINES_LOG2-1:OFFSET_WIDTH]; tag = remaining upper bits.
  - hit = entry tag matches and state != I.
- Reset (rst low, asynchronous):
  - All lines I, tags 0, FSM IDLE.
  - mbus_cmd_o = NOP, mbus_addr_o = 0, cbus_ack_o = 0, cpu_done_o = 0, cpu_ready_o = 0.
  - Any in-flight request is dropped; no completion is ever signalled for it.
- cpu_ready_o: 1 only in IDLE with cbus_cmd_i == NOP. A request is accepted when cpu_req_i && cpu_ready_o; cpu_addr_i and cpu_wr_i are captured on that edge.
- FSM states: IDLE, LOOKUP, EVICT, BROAD, WAIT_EN, SNP_WB, SNP_ACK, ACK_GAP.
- IDLE:
  - Any cbus_cmd_i != NOP goes to snoop service first (snoop priority over new CPU requests).
  - Otherwise an accepted request goes to LOOKUP.
- LOOKUP (1 cycle):
  - Read hit → cpu_done_o pulses next cycle, state unchanged.
  - Write hit in E or M → state M, cpu_done_o next cycle (silent upgrade).
  - Write hit in S → BROAD with WR_BROAD.
  - Miss with victim in M → EVICT. Other misses → BROAD (RD_BROAD for a read, WR_BROAD for a write).
- mbus handshake rules:
  - Drive cmd and address from the cycle after the decision.
  - Hold both stable until the edge where mbus_ack_i = 1.
  - mbus_cmd_o = NOP in the following cycle.
- EVICT: mbus WR to the victim line address. On ack: victim → I, then BROAD.
- BROAD: on ack → WAIT_EN.
- WAIT_EN:
  - Wait for EN_RD (read) or EN_WR (write) with a line-aligned cbus_addr_i match.
  - On that command: cbus_ack_o pulses one cycle, tag is written, state S for a read or M for a write, cpu_done_o pulses in the same cycle.
  - Snoops arriving in WAIT_EN are serviced, then the FSM returns to WAIT_EN (deadlock avoidance).
- Snoop service, line-aligned compare:
  - WR_SNOOP: hit in M → SNP_WB (mbus WR), then line → I. Any other hit → I. Miss → no change.
  - RD_SNOOP: hit in M → SNP_WB, then S. E → S. S or miss → no change.
  - SNP_ACK: cbus_ack_o = 1 for exactly one cycle.
  - Latency: without writeback, ack in the 2nd cycle after the command appears. With writeback, ack 1 cycle after mbus_ack_i.
  - EN_RD or EN_WR received with no request pending, or with a non-matching address: acked, no state change.
- ACK_GAP: after every cbus_ack_o pulse, cbus_cmd_i is ignored for one cycle (mesi_isc deasserts the command).
- Simultaneous events:
  - A cbus command and cpu_req_i in the same IDLE cycle: cpu_ready_o = 0, so the snoop wins.
  - A snoop that invalidates the index of a pending miss does not cancel the miss. The EN_* fill overwrites the entry.

Test Plan:
- Reset, then read 0x100 → mbus_cmd_o=4 (RD_BROAD), addr 0x100 held until mbus_ack_i. Then cbus_cmd_i=4 (EN_RD) at 0x100 → cbus_ack_o one-cycle pulse, cpu_done_o pulse, line state S.
- Read 0x100 again → cpu_done_o 2 cycles after acceptance, mbus_cmd_o stays 0.
- Write 0x100 (state S) → WR_BROAD (3), then EN_WR → ack, state M. A second write to 0x102 completes with no mbus activity.
- Line M at 0x100, cbus RD_SNOOP at 0x100 → mbus WR (1) 0x100. After mbus_ack_i, cbus_ack_o pulse and state S. With the line in S, the same snoop acks in 2 cycles with no mbus traffic.
- Line M at 0x100, read 0x110 (same index 0) → mbus WR 0x100, then RD_BROAD 0x110. After EN_RD, tag 0x110 is installed in state S.
- In WAIT_EN for 0x200, cbus WR_SNOOP at 0x300 (miss) → ack, no state change. Then EN_RD at 0x200 completes the request. Assert rst mid-BROAD → all outputs at reset values immediately and no cpu_done_o pulse.

Source files
------------

// File: rtl/mesi_cpu_agent.sv
// Per-CPU MESI coherence agent: issues main-bus requests toward mesi_isc and
// services coherence-bus snoops/enables against a small direct-mapped tag/state table.
module mesi_cpu_agent #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int LINES_LOG2     = 2,
  parameter int OFFSET_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_i,
  input  logic                      cpu_wr_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
  output logic                      cpu_ready_o,
  output logic                      cpu_done_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o
);

  localparam int LINES  = 1 << LINES_LOG2;
  localparam int LN_W   = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int TAG_W  = LN_W - LINES_LOG2;
  localparam int TAG_LO = OFFSET_WIDTH + LINES_LOG2;

  localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP      = '0;
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR       = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD_BROAD = MBUS_CMD_WIDTH'(4);

  localparam logic [CBUS_CMD_WIDTH-1:0] CB_NOP      = '0;
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, EVICT, BROAD, WAIT_EN, SNP_WB, SNP_ACK, ACK_GAP
  } state_t;

  typedef enum logic [1:0] {LS_I = 2'd0, LS_S = 2'd1, LS_E = 2'd2, LS_M = 2'd3} line_t;

  state_t                  state;
  line_t                   lst  [LINES];
  logic [TAG_W-1:0]        ltag [LINES];
  logic                    pend;
  logic                    req_wr;
  logic [LN_W-1:0]         req_line;
  logic                    snp_wr;

  logic [LINES_LOG2-1:0]   r_idx, s_idx, w_idx;
  logic [TAG_W-1:0]        r_tag, s_tag;
  logic [LN_W-1:0]         s_line;
  logic                    r_hit, s_hit, is_snoop, en_match;
  logic [MBUS_CMD_WIDTH-1:0] bcast_cmd;
  logic                    unused_ok;

  assign unused_ok = &{1'b0, cpu_addr_i[OFFSET_WIDTH-1:0], cbus_addr_i[OFFSET_WIDTH-1:0]};

  always_comb begin
    r_idx     = req_line[LINES_LOG2-1:0];
    r_tag     = req_line[LN_W-1:LINES_LOG2];
    s_line    = cbus_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
    s_idx     = s_line[LINES_LOG2-1:0];
    s_tag     = s_line[LN_W-1:LINES_LOG2];
    w_idx     = mbus_addr_o[TAG_LO-1:OFFSET_WIDTH];
    r_hit     = (lst[r_idx] != LS_I) && (ltag[r_idx] == r_tag);
    s_hit     = (lst[s_idx] != LS_I) && (ltag[s_idx] == s_tag);
    is_snoop  = (cbus_cmd_i == CB_WR_SNOOP) || (cbus_cmd_i == CB_RD_SNOOP);
    en_match  = pend && (s_line == req_line) &&
                (req_wr ? (cbus_cmd_i == CB_EN_WR) : (cbus_cmd_i == CB_EN_RD));
    bcast_cmd = req_wr ? MB_WR_BROAD : MB_RD_BROAD;
  end

  assign cpu_ready_o = rst && (state == IDLE) && (cbus_cmd_i == CB_NOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lst         <= '{default: LS_I};
      ltag        <= '{default: '0};
      pend        <= 1'b0;
      req_wr      <= 1'b0;
      req_line    <= '0;
      snp_wr      <= 1'b0;
      mbus_cmd_o  <= MB_NOP;
      mbus_addr_o <= '0;
      cbus_ack_o  <= 1'b0;
      cpu_done_o  <= 1'b0;
    end else begin
      cpu_done_o <= 1'b0;
      cbus_ack_o <= 1'b0;
      case (state)
        // IDLE and WAIT_EN share snoop service; pend steers ACK_GAP back to the right one.
        IDLE, WAIT_EN: begin
          if (state == WAIT_EN && en_match) begin
            ltag[r_idx] <= r_tag;
            lst[r_idx]  <= req_wr ? LS_M : LS_S;
            cbus_ack_o  <= 1'b1;
            cpu_done_o  <= 1'b1;
            pend        <= 1'b0;
            state       <= ACK_GAP;
          end else if (cbus_cmd_i != CB_NOP) begin
            if (is_snoop && s_hit && lst[s_idx] == LS_M) begin
              mbus_cmd_o  <= MB_WR;
              mbus_addr_o <= {s_line, {OFFSET_WIDTH{1'b0}}};
              snp_wr      <= (cbus_cmd_i == CB_WR_SNOOP);
              state       <= SNP_WB;
            end else begin
              if (s_hit && cbus_cmd_i == CB_WR_SNOOP) lst[s_idx] <= LS_I;
              if (s_hit && cbus_cmd_i == CB_RD_SNOOP && lst[s_idx] == LS_E) lst[s_idx] <= LS_S;
              state <= SNP_ACK;
            end
          end else if (state == IDLE && cpu_req_i) begin
            req_line <= cpu_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
            req_wr   <= cpu_wr_i;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (r_hit && (!req_wr || lst[r_idx] != LS_S)) begin
            if (req_wr) lst[r_idx] <= LS_M;
            cpu_done_o <= 1'b1;
            state      <= IDLE;
          end else begin
            pend <= 1'b1;
            if (!r_hit && lst[r_idx] == LS_M) begin
              mbus_cmd_o  <= MB_WR;
              mbus_addr_o <= {ltag[r_idx], r_idx, {OFFSET_WIDTH{1'b0}}};
              state       <= EVICT;
            end else begin
              mbus_cmd_o  <= bcast_cmd;
              mbus_addr_o <= {req_line, {OFFSET_WIDTH{1'b0}}};
              state       <= BROAD;
            end
          end
        end
        EVICT: begin
          if (mbus_ack_i) begin
            lst[r_idx] <= LS_I;
            mbus_cmd_o <= MB_NOP;
            state      <= BROAD;
          end
        end
        // Entered with NOP after an eviction: load the broadcast first, then wait for its ack.
        BROAD: begin
          if (mbus_cmd_o == MB_NOP) begin
            mbus_cmd_o  <= bcast_cmd;
            mbus_addr_o <= {req_line, {OFFSET_WIDTH{1'b0}}};
          end else if (mbus_ack_i) begin
            mbus_cmd_o <= MB_NOP;
            state      <= WAIT_EN;
          end
        end
        SNP_WB: begin
          if (mbus_ack_i) begin
            lst[w_idx] <= snp_wr ? LS_I : LS_S;
            mbus_cmd_o <= MB_NOP;
            cbus_ack_o <= 1'b1;
            state      <= ACK_GAP;
          end
        end
        SNP_ACK: begin
          cbus_ack_o <= 1'b1;
          state      <= ACK_GAP;
        end
        ACK_GAP: state <= pend ? WAIT_EN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_cpu_agent.sv
// Directed bench for mesi_cpu_agent: a vector table of CPU accesses with the
// expected main-bus traffic, plus hand-written snoop, WAIT_EN and reset sequences.
module tb_mesi_cpu_agent;

  localparam logic [2:0] MB_WR  = 3'd1, WR_B = 3'd3, RD_B = 3'd4;
  localparam logic [2:0] WR_SNP = 3'd1, RD_SNP = 3'd2, EN_WR = 3'd3, EN_RD = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready, cpu_done;
  logic [2:0]  mbus_cmd;
  logic [31:0] mbus_addr;
  logic        mbus_ack = 1'b0;
  logic [2:0]  cbus_cmd = '0;
  logic [31:0] cbus_addr = '0;
  logic        cbus_ack;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic        ev;
    logic [31:0] ev_addr;
    logic [2:0]  bc;       // 0 = hit, no bus traffic expected
    logic [31:0] bc_addr;
  } vec_t;

  vec_t vecs [13];

  mesi_cpu_agent #(
    .ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3), .LINES_LOG2(2), .OFFSET_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr),
    .cpu_ready_o(cpu_ready), .cpu_done_o(cpu_done),
    .mbus_cmd_o(mbus_cmd), .mbus_addr_o(mbus_addr), .mbus_ack_i(mbus_ack),
    .cbus_cmd_i(cbus_cmd), .cbus_addr_i(cbus_addr), .cbus_ack_o(cbus_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cpu_done) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic ev,
                              input logic [31:0] ev_addr, input logic [2:0] bc,
                              input logic [31:0] bc_addr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.ev = ev; v.ev_addr = ev_addr; v.bc = bc; v.bc_addr = bc_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    while (!cpu_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic serve_mbus(input logic [2:0] c, input logic [31:0] a);
    int n = 0;
    while (mbus_cmd == 3'd0 && n < 20) begin @(negedge clk); n++; end
    chk("mbus_timeout", 32'(n < 20), 32'd1);
    chk("mbus_cmd", 32'(mbus_cmd), 32'(c));
    chk("mbus_addr", mbus_addr, a);
    @(negedge clk);
    chk("mbus_hold_cmd", 32'(mbus_cmd), 32'(c));
    chk("mbus_hold_addr", mbus_addr, a);
    mbus_ack = 1'b1;
    @(negedge clk);
    mbus_ack = 1'b0;
    chk("mbus_nop_after_ack", 32'(mbus_cmd), 32'd0);
  endtask

  task automatic en_fill(input logic [2:0] c, input logic [31:0] a);
    @(negedge clk);
    cbus_cmd = c; cbus_addr = a;
    @(negedge clk);
    chk("fill_ack", 32'(cbus_ack), 32'd1);
    chk("fill_done", 32'(cpu_done), 32'd1);
    cbus_cmd = 3'd0;
    @(negedge clk);
    chk("fill_pulse", 32'({cbus_ack, cpu_done}), 32'd0);
  endtask

  task automatic snoop(input logic [2:0] c, input logic [31:0] a, input logic wb,
                       input logic [31:0] wba, input logic with_req);
    int d0;
    int n = 0;
    d0 = done_cnt;
    @(negedge clk);
    cbus_cmd = c; cbus_addr = a;
    if (with_req) begin cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h100; end
    #1 chk("snp_ready", 32'(cpu_ready), 32'd0);
    if (wb) begin
      while (mbus_cmd == 3'd0 && n < 20) begin @(negedge clk); n++; end
      chk("wb_timeout", 32'(n < 20), 32'd1);
      chk("wb_cmd", 32'(mbus_cmd), 32'(MB_WR));
      chk("wb_addr", mbus_addr, wba);
      @(negedge clk);
      chk("wb_hold_cmd", 32'(mbus_cmd), 32'(MB_WR));
      chk("wb_early_ack", 32'(cbus_ack), 32'd0);
      mbus_ack = 1'b1;
      @(negedge clk);
      mbus_ack = 1'b0;
      chk("wb_cbus_ack", 32'(cbus_ack), 32'd1);
      chk("wb_nop_after_ack", 32'(mbus_cmd), 32'd0);
    end else begin
      @(negedge clk);
      chk("snp_ack_c1", 32'(cbus_ack), 32'd0);
      chk("snp_no_mbus", 32'(mbus_cmd), 32'd0);
      @(negedge clk);
      chk("snp_ack_c2", 32'(cbus_ack), 32'd1);
    end
    cbus_cmd = 3'd0;
    @(negedge clk);
    chk("snp_ack_pulse", 32'(cbus_ack), 32'd0);
    if (with_req) cpu_req = 1'b0;
    chk("snp_no_done", 32'(done_cnt), 32'(d0));
  endtask

  task automatic process_vec(input vec_t v);
    int lat = 1;
    logic seen = 1'b0;
    do_req(v.wr, v.addr);
    if (v.bc == 3'd0) begin
      while (!cpu_done && lat < 20) begin
        if (mbus_cmd != 3'd0) seen = 1'b1;
        @(negedge clk);
        lat++;
      end
      chk("hit_latency", 32'(lat), 32'd2);
      chk("hit_no_mbus", 32'(seen), 32'd0);
      @(negedge clk);
      chk("hit_done_pulse", 32'(cpu_done), 32'd0);
    end else begin
      if (v.ev) serve_mbus(MB_WR, v.ev_addr);
      serve_mbus(v.bc, v.bc_addr);
      en_fill(v.wr ? EN_WR : EN_RD, v.bc_addr);
    end
  endtask

  initial begin
    int d0;
    int n;
    vecs[0]  = mk(1'b0, 32'h100, 1'b0, 32'h0,   RD_B, 32'h100);
    vecs[1]  = mk(1'b0, 32'h100, 1'b0, 32'h0,   3'd0, 32'h0);
    vecs[2]  = mk(1'b1, 32'h100, 1'b0, 32'h0,   WR_B, 32'h100);
    vecs[3]  = mk(1'b1, 32'h102, 1'b0, 32'h0,   3'd0, 32'h0);
    vecs[4]  = mk(1'b0, 32'h103, 1'b0, 32'h0,   3'd0, 32'h0);
    vecs[5]  = mk(1'b0, 32'h110, 1'b1, 32'h100, RD_B, 32'h110);
    vecs[6]  = mk(1'b0, 32'h100, 1'b0, 32'h0,   RD_B, 32'h100);
    vecs[7]  = mk(1'b1, 32'h204, 1'b0, 32'h0,   WR_B, 32'h204);
    vecs[8]  = mk(1'b0, 32'h207, 1'b0, 32'h0,   3'd0, 32'h0);
    vecs[9]  = mk(1'b1, 32'h214, 1'b1, 32'h204, WR_B, 32'h214);
    vecs[10] = mk(1'b1, 32'h10E, 1'b0, 32'h0,   WR_B, 32'h10C);
    vecs[11] = mk(1'b1, 32'h10F, 1'b0, 32'h0,   3'd0, 32'h0);
    vecs[12] = mk(1'b1, 32'h100, 1'b0, 32'h0,   WR_B, 32'h100);

    #3;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_mbus_cmd", 32'(mbus_cmd), 32'd0);
    chk("rst_mbus_addr", mbus_addr, 32'd0);
    chk("rst_cbus_ack", 32'(cbus_ack), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_after_rst", 32'(cpu_ready), 32'd1);

    for (int i = 0; i < 13; i++) process_vec(vecs[i]);

    // M line read-snooped: writeback then S; repeat snoop is a plain 2-cycle ack.
    snoop(RD_SNP, 32'h101, 1'b1, 32'h100, 1'b0);
    snoop(RD_SNP, 32'h100, 1'b0, 32'h0, 1'b0);
    process_vec(mk(1'b0, 32'h100, 1'b0, 32'h0, 3'd0, 32'h0));
    process_vec(mk(1'b1, 32'h100, 1'b0, 32'h0, WR_B, 32'h100));

    // Write snoop on M: writeback then I; second one misses.
    snoop(WR_SNP, 32'h216, 1'b1, 32'h214, 1'b0);
    snoop(WR_SNP, 32'h214, 1'b0, 32'h0, 1'b0);
    process_vec(mk(1'b0, 32'h214, 1'b0, 32'h0, RD_B, 32'h214));

    // Tag-mismatch snoop and idle EN_RD leave line 0x100 in M.
    snoop(RD_SNP, 32'h310, 1'b0, 32'h0, 1'b0);
    snoop(EN_RD, 32'h100, 1'b0, 32'h0, 1'b0);
    process_vec(mk(1'b1, 32'h103, 1'b0, 32'h0, 3'd0, 32'h0));

    // Snoops while waiting for the enable of a pending read miss.
    do_req(1'b0, 32'h208);
    serve_mbus(RD_B, 32'h208);
    snoop(WR_SNP, 32'h308, 1'b0, 32'h0, 1'b0);
    snoop(EN_WR, 32'h208, 1'b0, 32'h0, 1'b0);
    snoop(EN_RD, 32'h20C, 1'b0, 32'h0, 1'b0);
    snoop(WR_SNP, 32'h10D, 1'b1, 32'h10C, 1'b0);
    en_fill(EN_RD, 32'h20A);
    process_vec(mk(1'b0, 32'h209, 1'b0, 32'h0, 3'd0, 32'h0));
    process_vec(mk(1'b0, 32'h10C, 1'b0, 32'h0, RD_B, 32'h10C));

    // Snoop and CPU request in the same idle cycle: snoop wins.
    snoop(RD_SNP, 32'h380, 1'b0, 32'h0, 1'b1);
    process_vec(mk(1'b0, 32'h100, 1'b0, 32'h0, 3'd0, 32'h0));

    // Reset while a broadcast is outstanding.
    do_req(1'b1, 32'h38);
    n = 0;
    while (mbus_cmd == 3'd0 && n < 20) begin @(negedge clk); n++; end
    chk("broad_before_rst", 32'(mbus_cmd), 32'(WR_B));
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    chk("midrst_mbus_cmd", 32'(mbus_cmd), 32'd0);
    chk("midrst_mbus_addr", mbus_addr, 32'd0);
    chk("midrst_ready", 32'(cpu_ready), 32'd0);
    chk("midrst_done", 32'(cpu_done), 32'd0);
    chk("midrst_cbus_ack", 32'(cbus_ack), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("postrst_no_done", 32'(done_cnt), 32'(d0));
    chk("postrst_mbus_idle", 32'(mbus_cmd), 32'd0);
    process_vec(mk(1'b0, 32'h208, 1'b0, 32'h0, RD_B, 32'h208));
    process_vec(mk(1'b0, 32'h100, 1'b0, 32'h0, RD_B, 32'h100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
